pwm_capture: RTL and testbench

Bus-programmable PWM input decoder: the receive-side counterpart of the team's `pwm` generator. It synchronises an external PWM line and measures each full cycle in clock cycles, reporting high time and period. It also counts completed captures and flags stuck-high and stuck-low lines via a programmable timeout. It sits on the same valid/ready register bus as `pwm` and raises a level interrupt on each new sample.

---
 rtl/pwm_capture.sv | 177 +++++++++++++++++
 tb/tb_pwm_capture.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM input decoder: synchronises an external PWM line, measures high time and period
// per full cycle, counts captures, flags stuck lines, and exposes it on a valid/ready bus.
module pwm_capture #(
    parameter int BITS = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic            we_i,
    input  logic [BITS-1:0] addr_i,
    input  logic [BITS-1:0] wdata_i,
    output logic            ready_o,
    output logic [BITS-1:0] rdata_o,
    input  logic            cio_pwm_i,
    output logic            irq_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [BITS-1:0] CNT_MAX = '1;
    localparam logic [BITS-1:0] CNT_ONE = BITS'(1);

    logic            ready_q, ready_d;
    logic [BITS-1:0] rdata_q, rdata_d;
    logic [1:0]      sync_q, sync_d;
    logic            s_dly_q, s_dly_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [BITS-1:0] timeout_q, timeout_d;
    logic [BITS-1:0] high_q, high_d;
    logic [BITS-1:0] period_q, period_d;
    logic [BITS-1:0] count_q, count_d;
    logic [BITS-1:0] cnt_q, cnt_d;
    logic [BITS-1:0] hi_len_q, hi_len_d;
    logic [3:0]      flags_q, flags_d;
    logic [1:0]      state_q, state_d;
    logic            irq_q, irq_d;

    logic            s, rise, fall, acc, wr, tmo_hit;
    logic [5:0]      idx;
    logic [3:0]      w1c, set;
    logic [BITS-1:0] rd_val, cnt_inc;
    logic            addr_unused;

    assign addr_unused = ^addr_i;

    always_comb begin
        s       = sync_q[1] ^ ctrl_q[1];
        rise    = s & ~s_dly_q;
        fall    = ~s & s_dly_q;
        sync_d  = {sync_q[0], cio_pwm_i};
        s_dly_d = s;

        acc = valid_i & ~ready_q;
        wr  = acc & we_i;
        idx = addr_i[7:2];

        case (idx)
            6'd0:    rd_val = {{(BITS-3){1'b0}}, ctrl_q};
            6'd1:    rd_val = {{(BITS-6){1'b0}}, state_q, flags_q};
            6'd2:    rd_val = high_q;
            6'd3:    rd_val = period_q;
            6'd4:    rd_val = timeout_q;
            6'd5:    rd_val = count_q;
            default: rd_val = '0;
        endcase

        ready_d   = acc;
        rdata_d   = (acc && !we_i) ? rd_val : rdata_q;
        ctrl_d    = (wr && idx == 6'd0) ? wdata_i[2:0] : ctrl_q;
        timeout_d = (wr && idx == 6'd4) ? wdata_i : timeout_q;
        w1c       = (wr && idx == 6'd1) ? wdata_i[3:0] : 4'b0;

        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        tmo_hit = (timeout_q != '0) && (cnt_q == timeout_q);

        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_len_d = hi_len_q;
        high_d   = high_q;
        period_d = period_q;
        count_d  = count_q;
        set      = 4'b0;

        if (!ctrl_q[0]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // the edge takes priority over a coincident timeout
                    if (fall) begin
                        hi_len_d = cnt_q;
                        cnt_d    = cnt_inc;
                        state_d  = ST_LOW;
                    end else if (tmo_hit) begin
                        set[1]  = 1'b1;
                        state_d = ST_ARM;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hi_len_q;
                        count_d  = count_q + CNT_ONE;
                        set[0]   = 1'b1;
                        set[3]   = (cnt_q == CNT_MAX) || (hi_len_q == CNT_MAX);
                        cnt_d    = CNT_ONE;
                        state_d  = ST_HIGH;
                    end else if (tmo_hit) begin
                        set[2]  = 1'b1;
                        state_d = ST_ARM;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end

        // hardware set wins over a same-cycle write-one-to-clear
        flags_d = (flags_q & ~w1c) | set;
        irq_d   = flags_q[0] & ctrl_q[2];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            sync_q    <= '0;
            s_dly_q   <= 1'b0;
            ctrl_q    <= '0;
            timeout_q <= '0;
            high_q    <= '0;
            period_q  <= '0;
            count_q   <= '0;
            cnt_q     <= '0;
            hi_len_q  <= '0;
            flags_q   <= '0;
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            sync_q    <= sync_d;
            s_dly_q   <= s_dly_d;
            ctrl_q    <= ctrl_d;
            timeout_q <= timeout_d;
            high_q    <= high_d;
            period_q  <= period_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            hi_len_q  <= hi_len_d;
            flags_q   <= flags_d;
            state_q   <= state_d;
            irq_q     <= irq_d;
        end
    end

    assign ready_o = ready_q;
    assign rdata_o = rdata_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model compared every cycle on the bus
// outputs and irq, plus directed scenarios with hand-computed register values.
module tb_pwm_capture;
    localparam int B = 8;

    logic         clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, we_i = 1'b0, cio_pwm_i = 1'b0;
    logic [B-1:0] addr_i = '0, wdata_i = '0;
    logic [B-1:0] rdata_o;
    logic         ready_o, irq_o;

    int errors = 0, checks = 0;
    bit chk_on = 1'b0;

    pwm_capture #(.BITS(B)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .rdata_o(rdata_o),
        .cio_pwm_i(cio_pwm_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // PWM source: 0 hold low, 1 hold high, 2 periodic pattern
    int pmode = 0, pp = 4, ph = 2, pcnt = 0;
    initial forever begin
        @(negedge clk_i);
        if (pmode == 2) begin
            cio_pwm_i = (pcnt < ph);
            pcnt = (pcnt + 1 >= pp) ? 0 : pcnt + 1;
        end else begin
            cio_pwm_i = (pmode == 1);
        end
    end

    task automatic start_pat(input int p, input int h);
        pp = p; ph = h; pcnt = 0; pmode = 2;
    endtask

    // Reference model: measurements come from edge timestamps, clipped at all-ones.
    logic [2:0] m_ctrl;
    logic [7:0] m_tmo, m_high, m_period, m_count, m_rdata;
    logic [3:0] m_fl;
    logic       m_p1, m_p2, m_sd, m_rdy, m_irq;
    int         m_mode, m_cyc, m_trise, m_tfall;

    task automatic mreset();
        m_ctrl = '0; m_tmo = '0; m_high = '0; m_period = '0; m_count = '0; m_rdata = '0;
        m_fl = '0; m_p1 = 0; m_p2 = 0; m_sd = 0; m_rdy = 0; m_irq = 0;
        m_mode = 0; m_cyc = 0; m_trise = 0; m_tfall = 0;
    endtask

    task automatic mstep();
        logic s, rise, fall, acc, irq_n;
        logic [3:0] w1c, set;
        logic [7:0] rv;
        int idx, el, cnt, hl, nmode;
        s = m_p2 ^ m_ctrl[1];
        rise = s & !m_sd;
        fall = !s & m_sd;
        el = m_cyc - m_trise;
        cnt = (el > 255) ? 255 : el;
        acc = valid_i & !m_rdy;
        idx = int'(addr_i[7:2]);
        case (idx)
            0: rv = {5'b0, m_ctrl};
            1: rv = {2'b0, 2'(m_mode), m_fl};
            2: rv = m_high;
            3: rv = m_period;
            4: rv = m_tmo;
            5: rv = m_count;
            default: rv = 8'h00;
        endcase
        w1c = (acc && we_i && idx == 1) ? wdata_i[3:0] : 4'b0;
        set = 4'b0;
        nmode = m_mode;
        if (!m_ctrl[0]) nmode = 0;
        else case (m_mode)
            0: nmode = 1;
            1: if (rise) begin m_trise = m_cyc; nmode = 2; end
            2: if (fall) begin m_tfall = m_cyc; nmode = 3; end
               else if (m_tmo != 0 && cnt == int'(m_tmo)) begin set[1] = 1; nmode = 1; end
            default: if (rise) begin
                    hl = (m_tfall - m_trise > 255) ? 255 : m_tfall - m_trise;
                    m_period = 8'(cnt);
                    m_high = 8'(hl);
                    m_count = m_count + 8'd1;
                    set[0] = 1;
                    set[3] = (cnt == 255) || (hl == 255);
                    m_trise = m_cyc;
                    nmode = 2;
                end else if (m_tmo != 0 && cnt == int'(m_tmo)) begin
                    set[2] = 1; nmode = 1;
                end
        endcase
        irq_n = m_fl[0] & m_ctrl[2];
        m_fl = (m_fl & ~w1c) | set;
        m_mode = nmode;
        m_irq = irq_n;
        if (acc && !we_i) m_rdata = rv;
        m_rdy = acc;
        if (acc && we_i && idx == 0) m_ctrl = wdata_i[2:0];
        if (acc && we_i && idx == 4) m_tmo = wdata_i;
        m_sd = s;
        m_p2 = m_p1;
        m_p1 = cio_pwm_i;
        m_cyc++;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) mreset();
            else mstep();
        end
    end

    // cycle-by-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk_i);
        if (chk_on) begin
            checks++;
            if ({ready_o, irq_o, rdata_o} !== {m_rdy, m_irq, m_rdata}) begin
                errors++;
                $display("FAIL cycle t=%0t: ready/irq/rdata got %b/%b/%0h expected %b/%b/%0h",
                         $time, ready_o, irq_o, rdata_o, m_rdy, m_irq, m_rdata);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] r);
        int n;
        @(negedge clk_i);
        valid_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ready_o && n < 10);
        checks++;
        if (!ready_o) begin
            errors++;
            $display("FAIL bus_ready: no ready after %0d cycles, addr %0h", n, a);
        end
        r = rdata_o;
        valid_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        bus(1'b1, a, d, r);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] r);
        bus(1'b0, a, 8'h00, r);
    endtask

    logic [7:0] v, c0, p0, h0;

    initial begin
        #1 chk_on = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("reset_ready", int'(ready_o), 0);
        chk("reset_rdata", int'(rdata_o), 0);
        chk("reset_irq", int'(irq_o), 0);
        rst_ni = 1'b1;

        // P=100 H=30, irq enabled
        wr(8'h00, 8'h05);
        repeat (5) @(negedge clk_i);
        start_pat(100, 30);
        repeat (150) @(negedge clk_i);
        rd(8'h0C, v); chk("period_100", int'(v), 100);
        rd(8'h08, v); chk("high_30", int'(v), 30);
        rd(8'h14, v); chk("count_1", int'(v), 1);
        rd(8'h04, v); chk("status_new", int'(v & 8'h01), 1);
        chk("irq_set", int'(irq_o), 1);
        wr(8'h04, 8'h01);
        repeat (2) @(negedge clk_i);
        chk("irq_cleared", int'(irq_o), 0);

        // inverted input
        wr(8'h00, 8'h07);
        repeat (300) @(negedge clk_i);
        rd(8'h08, v); chk("inv_high_70", int'(v), 70);
        rd(8'h0C, v); chk("inv_period_100", int'(v), 100);

        // stuck high, then stuck low, TIMEOUT=50
        wr(8'h00, 8'h05);
        wr(8'h10, 8'd50);
        pmode = 0;
        repeat (120) @(negedge clk_i);
        wr(8'h04, 8'h0F);
        pmode = 1;
        repeat (100) @(negedge clk_i);
        rd(8'h04, v); chk("stuck_high_arm", int'(v & 8'h36), 8'h12);
        pmode = 0;
        repeat (20) @(negedge clk_i);
        wr(8'h04, 8'h0F);
        pmode = 1;
        repeat (5) @(negedge clk_i);
        pmode = 0;
        repeat (100) @(negedge clk_i);
        rd(8'h04, v); chk("stuck_low_arm", int'(v & 8'h36), 8'h14);

        // ten periods of P=4 H=2: first rise only arms
        wr(8'h10, 8'd0);
        repeat (10) @(negedge clk_i);
        rd(8'h14, c0);
        start_pat(4, 2);
        repeat (38) @(negedge clk_i);
        pmode = 0;
        repeat (10) @(negedge clk_i);
        rd(8'h14, v); chk("count_plus_9", int'(8'(v - c0)), 9);
        rd(8'h0C, v); chk("period_4", int'(v), 4);
        rd(8'h08, v); chk("high_2", int'(v), 2);

        // disable mid-HIGH keeps results
        start_pat(100, 60);
        repeat (230) @(negedge clk_i);
        rd(8'h0C, p0); chk("pre_dis_period", int'(p0), 100);
        rd(8'h08, h0); chk("pre_dis_high", int'(h0), 60);
        rd(8'h14, c0);
        wr(8'h00, 8'h00);
        rd(8'h04, v); chk("dis_state_idle", int'(v[5:4]), 0);
        rd(8'h0C, v); chk("dis_period_kept", int'(v), int'(p0));
        rd(8'h08, v); chk("dis_high_kept", int'(v), int'(h0));
        rd(8'h14, v); chk("dis_count_kept", int'(v), int'(c0));

        // saturation: period longer than counter range
        pmode = 0;
        wr(8'h00, 8'h01);
        wr(8'h04, 8'h0F);
        repeat (5) @(negedge clk_i);
        start_pat(300, 10);
        repeat (700) @(negedge clk_i);
        rd(8'h0C, v); chk("sat_period", int'(v), 255);
        rd(8'h08, v); chk("sat_high", int'(v), 10);
        rd(8'h04, v); chk("overflow", int'(v & 8'h08), 8);

        // unmapped read, write to read-only
        rd(8'h3C, v); chk("unmapped_zero", int'(v), 0);
        wr(8'h08, 8'hAA);
        rd(8'h08, v); chk("ro_high_kept", int'(v), 10);

        // randomized traffic checked by the model every cycle
        wr(8'h00, 8'h05);
        for (int it = 0; it < 40; it++) begin
            int p, nops;
            p = $urandom_range(2, 24);
            if ($urandom_range(0, 5) == 0) pmode = $urandom_range(0, 1);
            else start_pat(p, $urandom_range(1, p - 1));
            nops = $urandom_range(3, 12);
            for (int k = 0; k < nops; k++) begin
                logic [7:0] a, d;
                int sel;
                sel = $urandom_range(0, 6);
                a = (sel == 6) ? 8'h3C : 8'(sel * 4);
                d = 8'($urandom);
                if (sel == 0 && $urandom_range(0, 7) != 0) d[0] = 1'b1;
                if (sel == 4) d = 8'($urandom_range(0, 30));
                bus(1'($urandom_range(0, 1)), a, d, v);
                repeat ($urandom_range(0, 6)) @(negedge clk_i);
            end
        end

        // async reset mid-capture
        wr(8'h10, 8'd0);
        wr(8'h00, 8'h05);
        start_pat(4, 2);
        repeat (20) @(negedge clk_i);
        chk("pre_reset_irq", int'(irq_o), 1);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_ready", int'(ready_o), 0);
        chk("async_rdata", int'(rdata_o), 0);
        chk("async_irq", int'(irq_o), 0);
        pmode = 0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        rd(8'h00, v); chk("post_reset_ctrl", int'(v), 0);
        rd(8'h14, v); chk("post_reset_count", int'(v), 0);
        rd(8'h04, v); chk("post_reset_status", int'(v), 0);

        repeat (3) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
